decoder_nx2n_seq: RTL

DECODER_NX2N_SEQ -- requirements
Module: decoder_nx2n_seq

---
 rtl/decoder_pkg.sv | 13 +
 rtl/decoder_nx2n_seq_onehot_enc_sel.sv | 15 +
 rtl/decoder_nx2n_seq.sv | 127 ++++++++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// Shared FSM state type and default select width for the sequenced
// N-to-2^N decoder and its helpers.
package decoder_pkg;

  localparam int DEFAULT_SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

endpackage

// File: rtl/decoder_nx2n_seq_onehot_enc_sel.sv
// Combinational index-to-one-hot encoder with an enable; all-zero when disabled.
module onehot_enc_sel #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      i_sel,
  input  logic                  i_en,
  output logic [(2**SEL_W)-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_sel] = 1'b1;
  end

endmodule

// File: rtl/decoder_nx2n_seq.sv
// Registered N-to-2^N decoder with a valid/ready command port, a valid/ready
// result port, and an optional scan mode that sweeps every output line once.
module decoder_nx2n_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W   = DEFAULT_SEL_W,
  parameter int SCAN_EN = 1,
  localparam int OUT_W  = 2**SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_scan,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] out_idx,
  output logic             out_last
);

  localparam logic [SEL_W:0] LAST_CNT = {1'b0, {SEL_W{1'b1}}};

  state_t           r_state;
  state_t           w_nextState;
  logic [OUT_W-1:0] r_out;
  logic [SEL_W-1:0] r_idx;
  logic             r_last;
  logic             r_valid;
  logic [SEL_W:0]   r_cnt;

  logic             w_accept;
  logic             w_taken;
  logic             w_scanGo;
  logic             w_sweepDone;
  logic [SEL_W-1:0] w_nextIdx;
  logic [SEL_W:0]   w_cntInc;
  logic [SEL_W-1:0] w_encSel;
  logic             w_encEn;
  logic [OUT_W-1:0] w_encOut;

  assign w_accept    = in_valid && in_ready;
  assign w_taken     = r_valid && out_ready;
  assign w_scanGo    = in_scan && en && (SCAN_EN != 0);
  assign w_sweepDone = (r_cnt == LAST_CNT);
  assign w_nextIdx   = r_idx + SEL_W'(1);
  assign w_cntInc    = r_cnt + (SEL_W + 1)'(1);

  // A new command always wins the encoder; otherwise it prepares the next sweep index.
  assign w_encSel = w_accept ? in_sel : w_nextIdx;
  assign w_encEn  = w_accept ? en : 1'b1;

  onehot_enc_sel #(
    .SEL_W (SEL_W)
  ) u_enc (
    .i_sel    (w_encSel),
    .i_en     (w_encEn),
    .o_onehot (w_encOut)
  );

  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      case (r_state)
        IDLE:    in_ready = 1'b1;
        HOLD:    in_ready = out_ready;
        default: in_ready = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_nextState = w_scanGo ? SCAN : HOLD;
      end
      HOLD: begin
        if (w_accept)     w_nextState = w_scanGo ? SCAN : HOLD;
        else if (w_taken) w_nextState = IDLE;
      end
      SCAN: begin
        if (w_taken && w_sweepDone) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // Once the final beat leaves, out keeps its last value with valid dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_out   <= w_encOut;
      r_idx   <= en ? in_sel : '0;
      r_last  <= !w_scanGo;
      r_valid <= 1'b1;
      r_cnt   <= '0;
    end else if (w_taken) begin
      if (r_state == SCAN && !w_sweepDone) begin
        r_out  <= w_encOut;
        r_idx  <= w_nextIdx;
        r_cnt  <= w_cntInc;
        r_last <= (w_cntInc == LAST_CNT);
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out       = r_out;
  assign out_idx   = r_idx;
  assign out_last  = r_last;
  assign out_valid = r_valid;

endmodule
